// File: rtl/pc_sequencer.sv
// pc_sequencer: multicycle fetch/execute sequencer that computes the next value of an 8-bit PC register.
// Build option: define PC_SEQ_TIMEOUT_EN to compile in the fetch-ack timeout counter and the FAULT state.
module pc_sequencer #(
  parameter logic [7:0] HALT_OPCODE = 8'hFF,
  parameter int         ACK_TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        clear_n,
  input  logic        start,
  input  logic [7:0]  pc_in,
  output logic [7:0]  next_pc,
  output logic        imem_req,
  output logic [7:0]  imem_addr,
  input  logic        imem_ack,
  input  logic [7:0]  imem_rdata,
  output logic [7:0]  instr,
  output logic        instr_valid,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [7:0]  branch_target,
  output logic        halted,
  output logic        fault,
  output logic [15:0] retired
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    EXEC  = 3'd2,
    HALT  = 3'd3,
    FAULT = 3'd4
  } state_t;

  state_t state;

`ifdef PC_SEQ_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(ACK_TIMEOUT - 1);
  logic [7:0] ack_count;
`else
  // Without the timeout feature ACK_TIMEOUT has no effect.
  logic [7:0] unused_timeout;
  assign unused_timeout = 8'(ACK_TIMEOUT);
  assign fault          = 1'b0;
`endif

  // Fetch handshake: imem_req stays high for every FETCH cycle; the first cycle
  // with imem_ack high completes the fetch, and imem_ack in any other state is ignored.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state       <= IDLE;
      instr       <= 8'h00;
      retired     <= 16'h0000;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
`ifdef PC_SEQ_TIMEOUT_EN
      fault       <= 1'b0;
      ack_count   <= 8'h00;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= FETCH;
            imem_req <= 1'b1;
          end
        end
        FETCH: begin
          if (imem_ack) begin
            instr       <= imem_rdata;
            state       <= EXEC;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
`ifdef PC_SEQ_TIMEOUT_EN
            ack_count   <= 8'h00;
          end else begin
            ack_count <= ack_count + 8'd1;
            if (ack_count == TIMEOUT_LAST) begin
              state    <= FAULT;
              imem_req <= 1'b0;
              fault    <= 1'b1;
            end
`endif
          end
        end
        EXEC: begin
          if (!stall) begin
            retired     <= retired + 16'd1;
            instr_valid <= 1'b0;
            if (instr == HALT_OPCODE) begin
              state  <= HALT;
              halted <= 1'b1;
            end else begin
              state    <= FETCH;
              imem_req <= 1'b1;
            end
          end
        end
        default: ;  // HALT and FAULT are left only through clear_n
      endcase
    end
  end

  // The PC register reloads every edge, so "hold" means echoing pc_in back.
  always_comb begin
    next_pc = pc_in;
    if (state == EXEC && !stall && instr != HALT_OPCODE) begin
      next_pc = branch_taken ? branch_target : pc_in + 8'd1;
    end
  end

  assign imem_addr = pc_in;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed and randomized checks of pc_sequencer against a transaction-level PC/retire model.
module tb_pc_sequencer;

  localparam logic [7:0] HALT_OP = 8'hFF;
  localparam int         ACK_TO  = 16;

  logic        clock = 1'b0;
  logic        clear_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  pc_reg;
  logic [7:0]  next_pc;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack = 1'b0;
  logic [7:0]  imem_rdata = 8'h00;
  logic [7:0]  instr;
  logic        instr_valid;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [7:0]  branch_target = 8'h00;
  logic        halted;
  logic        fault;
  logic [15:0] retired;

  logic        pc_load = 1'b0;
  logic [7:0]  pc_load_val = 8'h00;

  int checks = 0;
  int errors = 0;
  int exp_pc = 0;
  int exp_retired = 0;

  pc_sequencer #(.HALT_OPCODE(HALT_OP), .ACK_TIMEOUT(ACK_TO)) dut (
    .clock(clock), .clear_n(clear_n), .start(start), .pc_in(pc_reg),
    .next_pc(next_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr),
    .instr_valid(instr_valid), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .halted(halted), .fault(fault),
    .retired(retired)
  );

  // clock / reset block
  always #5 clock = ~clock;

  // The PC register the sequencer steers; the bench can preload it while idle.
  always @(posedge clock) begin
    if (pc_load) pc_reg <= pc_load_val;
    else         pc_reg <= next_pc;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},     16'(imem_req),    16'h0);
    check({tag, "_valid"},   16'(instr_valid), 16'h0);
    check({tag, "_halted"},  16'(halted),      16'h0);
    check({tag, "_fault"},   16'(fault),       16'h0);
    check({tag, "_instr"},   16'(instr),       16'h0);
    check({tag, "_retired"}, retired,          16'h0);
    check({tag, "_next_pc"}, 16'(next_pc),     16'(pc_reg));
  endtask

  task automatic do_reset();
    clear_n = 1'b0;
    start = 1'b0; stall = 1'b0; imem_ack = 1'b0; branch_taken = 1'b0;
    pc_load = 1'b1; pc_load_val = 8'h00;
    step();
    step();
    pc_load = 1'b0;
    @(negedge clock);
    check_reset_outputs("reset");
    clear_n = 1'b1;
    step();
    exp_pc = 0;
    exp_retired = 0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'($urandom_range(0, 1));
  endtask

  // One instruction: FETCH with ack_delay idle cycles, EXEC with stall_cycles stalls, then retire.
  task automatic fetch_exec(input logic [7:0] data, input int ack_delay, input int stall_cycles,
                            input bit stall_branch, input bit br, input logic [7:0] tgt);
    int exp_next;
    for (int i = 0; i < ack_delay; i++) begin
      imem_ack = 1'b0;
      imem_rdata = 8'($urandom);
      @(negedge clock);
      check("fetch_req", 16'(imem_req), 16'h1);
      check("fetch_addr", 16'(imem_addr), 16'(exp_pc));
      check("fetch_next_pc", 16'(next_pc), 16'(exp_pc));
      step();
    end
    imem_ack = 1'b1;
    imem_rdata = data;
    @(negedge clock);
    check("ack_req", 16'(imem_req), 16'h1);
    check("ack_addr", 16'(imem_addr), 16'(exp_pc));
    check("ack_valid", 16'(instr_valid), 16'h0);
    step();
    for (int i = 0; i < stall_cycles; i++) begin
      stall = 1'b1;
      branch_taken = stall_branch ? 1'b1 : 1'($urandom_range(0, 1));
      branch_target = 8'($urandom);
      imem_ack = 1'($urandom_range(0, 1));
      imem_rdata = 8'($urandom);
      @(negedge clock);
      check("stall_valid", 16'(instr_valid), 16'h1);
      check("stall_instr", 16'(instr), 16'(data));
      check("stall_next_pc", 16'(next_pc), 16'(exp_pc));
      step();
    end
    stall = 1'b0;
    imem_ack = 1'($urandom_range(0, 1));
    imem_rdata = 8'($urandom);
    branch_taken = br;
    branch_target = tgt;
    if (data == HALT_OP) exp_next = exp_pc;
    else if (br)         exp_next = int'(tgt);
    else                 exp_next = (exp_pc + 1) % 256;
    @(negedge clock);
    check("exec_valid", 16'(instr_valid), 16'h1);
    check("exec_instr", 16'(instr), 16'(data));
    check("exec_next_pc", 16'(next_pc), 16'(exp_next));
    step();
    imem_ack = 1'b0;
    branch_taken = 1'b0;
    exp_pc = exp_next;
    exp_retired = (exp_retired + 1) % 65536;
    check("retire_count", retired, 16'(exp_retired));
    check("retire_pc", 16'(pc_reg), 16'(exp_pc));
    check("retire_halted", 16'(halted), 16'(data == HALT_OP));
    check("retire_req", 16'(imem_req), 16'(data != HALT_OP));
  endtask

  initial begin
    do_reset();

    // Straight-line fetch of three instructions with no ack delay.
    do_start();
    fetch_exec(8'h10, 0, 0, 1'b0, 1'b0, 8'h00);
    fetch_exec(8'h11, 0, 0, 1'b0, 1'b0, 8'h00);
    fetch_exec(8'h12, 0, 0, 1'b0, 1'b0, 8'h00);
    check("three_retired", retired, 16'd3);
    check("three_pc", 16'(pc_reg), 16'h03);

    // Branch taken at PC 05.
    fetch_exec(8'h13, 0, 0, 1'b0, 1'b0, 8'h00);
    fetch_exec(8'h14, 0, 0, 1'b0, 1'b0, 8'h00);
    check("pre_branch_pc", 16'(pc_reg), 16'h05);
    fetch_exec(8'h20, 0, 0, 1'b0, 1'b1, 8'h40);
    check("branch_pc", 16'(imem_addr), 16'h40);

    // Stall with branch asserted for four cycles, then a plain increment.
    fetch_exec(8'h21, 1, 4, 1'b1, 1'b0, 8'h00);
    check("stall_then_inc", 16'(pc_reg), 16'h41);

    // Randomized instruction stream.
    for (int n = 0; n < 30; n++) begin
      fetch_exec(8'($urandom_range(0, 254)), $urandom_range(0, 4), $urandom_range(0, 3),
                 1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
    end

    // PC wrap from FF to 00.
    fetch_exec(8'($urandom_range(0, 254)), 0, 0, 1'b0, 1'b1, 8'hFF);
    fetch_exec(8'h33, 0, 1, 1'b0, 1'b0, 8'h00);
    check("wrap_pc", 16'(pc_reg), 16'h00);

    // Halt at PC 07; start pulses must not restart it.
    fetch_exec(8'($urandom_range(0, 254)), 0, 0, 1'b0, 1'b1, 8'h07);
    fetch_exec(HALT_OP, 1, 0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      check("halt_sticky", 16'(halted), 16'h1);
      check("halt_pc", 16'(pc_reg), 16'h07);
      check("halt_req", 16'(imem_req), 16'h0);
      check("halt_retired", retired, 16'(exp_retired));
    end

    // Asynchronous reset in the middle of a FETCH cycle with ack pending.
    do_reset();
    do_start();
    imem_ack = 1'b1;
    imem_rdata = 8'h5A;
    #2;
    clear_n = 1'b0;
    #1;
    check_reset_outputs("async_fetch");
    step();
    check("async_no_latch", 16'(instr), 16'h00);
    imem_ack = 1'b0;
    start = 1'b0;
    @(negedge clock);
    clear_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("idle_wait_req", 16'(imem_req), 16'h0);
    end

`ifdef PC_SEQ_TIMEOUT_EN
    // Withheld ack: FAULT after ACK_TO FETCH cycles, then reset out of FAULT.
    do_reset();
    do_start();
    for (int i = 1; i <= ACK_TO; i++) begin
      imem_ack = 1'b0;
      @(negedge clock);
      check("to_req", 16'(imem_req), 16'h1);
      check("to_fault_low", 16'(fault), 16'h0);
      step();
    end
    check("to_fault", 16'(fault), 16'h1);
    check("to_req_drop", 16'(imem_req), 16'h0);
    start = 1'b1;
    imem_ack = 1'b1;
    step();
    step();
    start = 1'b0;
    imem_ack = 1'b0;
    check("to_sticky", 16'(fault), 16'h1);
    check("to_pc_hold", 16'(pc_reg), 16'h00);
    #2;
    clear_n = 1'b0;
    #1;
    check_reset_outputs("fault_reset");
    @(negedge clock);
    clear_n = 1'b1;
    step();
`else
    // Without the timeout feature FETCH waits indefinitely.
    do_reset();
    do_start();
    for (int i = 0; i < 3 * ACK_TO; i++) begin
      imem_ack = 1'b0;
      @(negedge clock);
      check("wait_req", 16'(imem_req), 16'h1);
      check("wait_fault", 16'(fault), 16'h0);
      step();
    end
    fetch_exec(8'h44, 0, 0, 1'b0, 1'b0, 8'h00);
    check("wait_done_pc", 16'(pc_reg), 16'h01);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Multicycle fetch/execute sequencer that drives the 8-bit program counter register.
- Fetches each instruction from instruction memory through a req/ack handshake and presents it to the datapath.
- Computes `next_pc` each cycle: hold, increment or branch. The PC register loads `next_pc` on every clock edge, so holding means feeding `pc_in` back.
- Detects the halt opcode, stalls on datapath request, flags instruction-memory timeouts and counts retired instructions.

## Interface
Parameters:
- `HALT_OPCODE`, 8'hFF, instruction encoding that stops the sequencer
- `ACK_TIMEOUT`, 16, cycles in FETCH without `imem_ack` before fault (valid range 1..255)

Ports:
- `clock`  in  1  system clock, rising edge
- `clear_n`  in  1  asynchronous, active-low reset
- `start`  in  1  level; leaves IDLE when high
- `pc_in`  in  8  current PC register value
- `next_pc`  out  8  value the PC register loads at the next edge (combinational)
- `imem_req`  out  1  instruction fetch request
- `imem_addr`  out  8  fetch address, equals `pc_in`
- `imem_ack`  in  1  fetch data valid this cycle
- `imem_rdata`  in  8  fetched instruction
- `instr`  out  8  registered current instruction
- `instr_valid`  out  1  high while in EXEC
- `stall`  in  1  datapath holds the current instruction in EXEC
- `branch_taken`  in  1  sampled in the final EXEC cycle
- `branch_target`  in  8  sampled with `branch_taken`
- `halted`  out  1  sequencer in HALT
- `fault`  out  1  sequencer in FAULT
- `retired`  out  16  retired-instruction count

## Operation
States: IDLE, FETCH, EXEC, HALT, FAULT. Encoding is free.

Reset (`clear_n` low):
- State IDLE; `instr`=8'h00; `retired`=0; timeout counter 0.
- `imem_req`, `instr_valid`, `halted`, `fault` = 0.
- `next_pc`=`pc_in`.

Transitions:
- IDLE → FETCH when `start`=1; otherwise stay.
- FETCH:
  - `imem_req`=1.
  - On `imem_ack`=1: latch `imem_rdata` into `instr`, go to EXEC, clear the timeout counter.
  - Otherwise the counter increments; when it reaches `ACK_TIMEOUT`, go to FAULT.
- EXEC, with `instr_valid`=1:
  - `stall`=1: stay.
  - `stall`=0 and `instr`==`HALT_OPCODE`: go to HALT; PC is not advanced; `retired` increments.
  - `stall`=0, other instruction: go to FETCH; `retired` increments.
- HALT, FAULT: sticky; exit only through `clear_n`. `start` is ignored.

`next_pc` rules:
- Equals `pc_in` in every state and cycle, except the final EXEC cycle (`stall`=0) of a non-halt instruction.
- In that cycle: `branch_taken` ? `branch_target` : `pc_in`+1.
- The increment is modulo 256 (8'hFF → 8'h00).
- `stall` and `branch_taken` together: `stall` wins and the branch is ignored that cycle.

`retired` wraps 16'hFFFF → 0.

`start` held high has no further effect outside IDLE.

## Timing
- Registered outputs: `instr`, `retired`, and the state-derived `imem_req`, `instr_valid`, `halted`, `fault`. Combinational: `next_pc`, `imem_addr`.
- `start` sampled at edge N: `imem_req` high in cycle N+1.
- `imem_ack` may arrive in the same cycle `imem_req` first goes high. The minimum instruction is then 2 cycles: FETCH, then EXEC.
- The PC register changes at the edge ending the last EXEC cycle. The following FETCH uses the new `pc_in`.
- `retired` updates at the same edge.
- `imem_ack` outside FETCH is ignored.
- Async reset mid-FETCH or mid-EXEC:
  - All state clears immediately; no partial latch of `instr`.
  - After release, the sequencer waits in IDLE for `start`.

## Configuration
Macro `PC_SEQ_TIMEOUT_EN`:
- Defined: timeout counter and FAULT state are compiled in, as described above.
- Undefined:
  - FETCH waits indefinitely for `imem_ack`.
  - FAULT is unreachable; `fault` is tied to 0.
  - `ACK_TIMEOUT` is unused.

## Test plan
- Reset, then `start`=1. Memory returns 8'h10, 8'h11, 8'h12 with ack delay 0. Required: PC runs 0→1→2→3; each instruction takes 2 cycles; `retired`=3.
- In EXEC at PC=8'h05, drive `branch_taken`=1, `branch_target`=8'h40. Required: next fetch `imem_addr`=8'h40; `retired` increments once.
- Hold `stall`=1 for 4 cycles with `branch_taken`=1. Required: `next_pc`=`pc_in` throughout. Then `stall`=0, `branch_taken`=0: PC+1.
- Start at PC=8'hFF with a non-halt instruction. Required: `next_pc`=8'h00.
- Instruction 8'hFF at PC=8'h07. Required: `halted`=1; `pc_in` stays 8'h07; `retired` increments; `start` pulses have no effect.
- With `PC_SEQ_TIMEOUT_EN` defined and `ACK_TIMEOUT`=16, withhold ack. Required: `fault`=1 after 16 FETCH cycles. Assert `clear_n` mid-FAULT: all outputs return to reset values.
